// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime baud divisor, 5..9 data bits, optional parity and 1/2 stop bits.
// Line is synchronised and majority-filtered; completed words sit in a one-entry valid/ready buffer.
module uart_rx_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic [DIV_W-1:0]  clks_per_bit,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LAST_IDX = 4'(DATA_W - 1);

  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction

  // odd = 1 flips the sense so that an odd total count of ones is the good case
  function automatic logic calc_par_err(input logic [DATA_W-1:0] d, input logic p, input logic odd);
    return (^d) ^ p ^ odd;
  endfunction

  state_t              r_state;
  logic [1:0]          r_sync;
  logic [2:0]          r_hist;
  logic [DIV_W-1:0]    r_cnt;
  logic [DIV_W-1:0]    r_cpb;
  logic [1:0]          r_pmode;
  logic                r_two_stop;
  logic [3:0]          r_bit_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par_calc;
  logic                r_done;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_parity_err;
  logic                r_frame_err;
  logic                r_overrun;

  logic                w_rx_s;
  logic                w_vote;
  logic [DIV_W-1:0]    w_half;
  logic [DIV_W-1:0]    w_last;
  logic                w_par_en;

  assign w_rx_s   = r_sync[1];
  assign w_vote   = maj3(r_hist);
  assign w_half   = r_cpb >> 1;
  assign w_last   = r_cpb - CNT_ONE;
  assign w_par_en = (r_pmode == 2'b01) || (r_pmode == 2'b10);

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

  // Line filter, frame state machine and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sync       <= 2'b11;
      r_hist       <= 3'b111;
      r_cnt        <= '0;
      r_cpb        <= '0;
      r_pmode      <= 2'b00;
      r_two_stop   <= 1'b0;
      r_bit_idx    <= 4'd0;
      r_shift      <= '0;
      r_par_calc   <= 1'b0;
      r_done       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], rx_in};
      r_hist      <= {r_hist[1:0], w_rx_s};
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_done      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_cpb      <= clks_per_bit;
            r_pmode    <= parity_mode;
            r_two_stop <= two_stop;
            r_par_calc <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == w_half) begin
            r_cnt     <= '0;
            r_bit_idx <= 4'd0;
            r_state   <= w_vote ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_cnt == w_last) begin
            r_cnt   <= '0;
            r_shift <= {w_vote, r_shift[DATA_W-1:1]};
            if (r_bit_idx == LAST_IDX) begin
              r_bit_idx <= 4'd0;
              r_state   <= w_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_PARITY: begin
          if (r_cnt == w_last) begin
            r_cnt      <= '0;
            r_par_calc <= calc_par_err(r_shift, w_vote, r_pmode == 2'b10);
            r_state    <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (r_cnt == w_last) begin
            r_cnt <= '0;
            if (!w_vote) begin
              r_frame_err <= 1'b1;
              r_bit_idx   <= 4'd0;
              r_state     <= S_BREAK;
            end else if (r_two_stop && (r_bit_idx == 4'd0)) begin
              r_bit_idx <= 4'd1;
            end else begin
              r_bit_idx <= 4'd0;
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_vote) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase

      // A draining buffer can take the new word in the same cycle.
      if (r_done) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data    <= r_shift;
          r_parity_err <= r_par_calc;
          r_rx_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

endmodule
